mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter SHALL be: READ_WAIT, default 1, number of WAIT cycles between the memory read strobe and data capture (legal range 1..7).
REQ-002 clk  input  1  system clock; every state change occurs on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0, req1  input  1 each  access request from port 0 / port 1.
REQ-005 we0, we1  input  1 each  1 = block write, 0 = block read.
REQ-006 addr0, addr1  input  5 each  block address (32 blocks of 16 x 32-bit words).
REQ-007 wdata0, wdata1  input  512 each  write block.
REQ-008 ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-009 rdata  output  512  read block returned to the acked port; valid only while its ack is high.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 mem_read, mem_write  output  1 each  strobes to main memory.
REQ-012 mem_addr  output  5  block address to main memory.
REQ-013 mem_wdata  output  512  write block to main memory.
REQ-014 mem_rdata  input  512  main memory read data, valid shortly after the rising edge that samples mem_read.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP; all outputs SHALL be registered or decoded from state registers only.
REQ-016 Requests SHALL be sampled only in IDLE; req0/req1 in other states SHALL be ignored.
REQ-017 IDLE, one request high: grant that port; IDLE, both high: grant the port not granted last (round robin); IDLE, none high: stay in IDLE.
REQ-018 On grant, the winner's we, addr and wdata SHALL be latched and the state SHALL go to ISSUE; the requester's later input changes SHALL have no effect on the transaction.
REQ-019 ISSUE lasts exactly one cycle: mem_addr = latched address, with mem_read = !we or mem_write = we; never both high.
REQ-020 mem_wdata SHALL equal the latched write block during ISSUE and all-zero otherwise.
REQ-021 Write: ISSUE -> RESP, because memory commits on the falling edge inside ISSUE. Read: ISSUE -> WAIT.
REQ-022 WAIT SHALL last READ_WAIT cycles, counted by a 3-bit counter; on its last edge mem_rdata SHALL be captured into rdata and the state SHALL go to RESP.
REQ-023 RESP lasts one cycle, with ack of the granted port high and the other ack low; then unconditionally -> IDLE.
REQ-024 Latency from the grant edge to ack high: write 1 cycle; read 2 + (READ_WAIT - 1) cycles.
REQ-025 A requester still holding req in the IDLE cycle after RESP SHALL be treated as a new request and arbitrated normally (no starvation; the other port wins if also requesting).
REQ-026 rdata SHALL hold its value until the next read capture; a write transaction SHALL leave rdata unchanged.
REQ-027 mem_read, mem_write and both acks SHALL be low outside ISSUE or RESP respectively.
REQ-028 The last-grant register SHALL update only on a grant.

Reset
REQ-029 While rst_n = 0: state IDLE; outputs ack0, ack1, busy, mem_read and mem_write = 0; rdata, mem_addr and mem_wdata = 0; WAIT counter = 0; last-grant = port 1, so port 0 wins the first contention.
REQ-030 Reset asserted mid-transaction SHALL abort it immediately: no ack is issued, and a memory strobe drops asynchronously.
REQ-031 After rst_n deasserts, the first request SHALL be sampled on the first rising edge.

Verification
REQ-032 Port 0 writes addr 3 with pattern A, then reads addr 3 (READ_WAIT = 1) -> mem_write in the cycle after the grant edge, ack0 one cycle after the grant; the read returns rdata = A with ack0 2 cycles after its grant edge.
REQ-033 req0 and req1 both high from reset for 4 transactions -> grant order 0, 1, 0, 1; every ack is exactly one cycle wide; ack0 and ack1 are never high together.
REQ-034 Port 1 read with READ_WAIT = 3 -> mem_read high for exactly 1 cycle, ack1 4 cycles after the grant edge; busy is high for the whole transaction.
REQ-035 addr0 and wdata0 changed the cycle after the grant -> memory still receives the originally latched address and data.
REQ-036 rst_n pulled low during WAIT -> outputs go to reset values immediately, no ack; a later request completes normally.
REQ-037 Port 0 holds req0 across ack0 while req1 is low -> a back-to-back second transaction starts in the IDLE cycle after RESP.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the main-memory port of the block arbiter.
interface mem_arbiter_if;
  logic         req0;
  logic         req1;
  logic         we0;
  logic         we1;
  logic [4:0]   addr0;
  logic [4:0]   addr1;
  logic [511:0] wdata0;
  logic [511:0] wdata1;
  logic         ack0;
  logic         ack1;
  logic [511:0] rdata;
  logic         busy;
  logic         mem_read;
  logic         mem_write;
  logic [4:0]   mem_addr;
  logic [511:0] mem_wdata;
  logic [511:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata, busy, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata, busy, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a 32 x 512-bit block memory.
// One transaction at a time: IDLE -> ISSUE -> (WAIT x READ_WAIT) -> RESP -> IDLE.
module mem_arbiter #(
  parameter int READ_WAIT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [2:0] WAIT_LAST = 3'(READ_WAIT - 1);

  logic [1:0]   state_q, state_d;
  logic [2:0]   waitCnt_q, waitCnt_d;
  logic         lastGrant_q, lastGrant_d;
  logic         we_q, we_d;
  logic [4:0]   addr_q, addr_d;
  logic [511:0] wdata_q, wdata_d;
  logic [511:0] rdata_q, rdata_d;
  logic         grantPort;

  // lastGrant_q doubles as the owner of the current transaction
  always_comb begin
    state_d     = state_q;
    waitCnt_d   = waitCnt_q;
    lastGrant_d = lastGrant_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    grantPort   = lastGrant_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          if (bus.req0 && bus.req1) grantPort = ~lastGrant_q;
          else                      grantPort = bus.req1;
          lastGrant_d = grantPort;
          we_d        = grantPort ? bus.we1    : bus.we0;
          addr_d      = grantPort ? bus.addr1  : bus.addr0;
          wdata_d     = grantPort ? bus.wdata1 : bus.wdata0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        waitCnt_d = 3'd0;
        state_d   = we_q ? RESP : WAIT;
      end
      WAIT: begin
        if (waitCnt_q == WAIT_LAST) begin
          rdata_d = bus.mem_rdata;
          state_d = RESP;
        end else begin
          waitCnt_d = waitCnt_q + 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Port 1 is the reset owner so port 0 wins the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      waitCnt_q   <= 3'd0;
      lastGrant_q <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= 5'd0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      waitCnt_q   <= waitCnt_d;
      lastGrant_q <= lastGrant_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_read  = (state_q == ISSUE) && !we_q;
  assign bus.mem_write = (state_q == ISSUE) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = (state_q == ISSUE) ? wdata_q : '0;
  assign bus.ack0      = (state_q == RESP) && !lastGrant_q;
  assign bus.ack1      = (state_q == RESP) && lastGrant_q;
  assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: dutA uses READ_WAIT = 1, dutB uses READ_WAIT = 3.
module tb_mem_arbiter;

  typedef struct {
    logic         port;
    logic [511:0] rdata;
    int           ackCycle;
  } resp_t;

  typedef struct {
    logic         isWrite;
    logic [4:0]   addr;
    logic [511:0] wdata;
  } memop_t;

  localparam logic [511:0] PAT_A  = {16{32'hA5A5_0003}};
  localparam logic [511:0] PAT_B  = {16{32'h0B0B_0007}};
  localparam logic [511:0] PAT_C  = {16{32'hC0C0_0008}};
  localparam logic [511:0] PAT_P0 = {16{32'h1111_0005}};
  localparam logic [511:0] PAT_P1 = {16{32'h2222_0006}};

  logic clk;
  logic rst_n;
  int   cycleCnt;
  int   assertCnt;
  int   failCnt;

  resp_t  respQA[$];
  resp_t  respQB[$];
  memop_t memQA[$];
  memop_t memQB[$];
  logic [511:0] rdExpA;
  logic [511:0] memA [32];

  mem_arbiter_if busA ();
  mem_arbiter_if busB ();

  mem_arbiter #(.READ_WAIT(1)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
  mem_arbiter #(.READ_WAIT(3)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  function automatic logic [511:0] patB(input logic [4:0] a);
    return {16{27'h2AAAAAA, a}};
  endfunction

  // Memory A commits writes on the falling edge inside ISSUE and returns reads after the sampling edge
  always @(negedge clk) if (busA.mem_write) memA[busA.mem_addr] = busA.mem_wdata;
  always @(posedge clk) if (busA.mem_read) busA.mem_rdata <= memA[busA.mem_addr];
  always @(posedge clk) if (busB.mem_read) busB.mem_rdata <= patB(busB.mem_addr);

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    assertCnt++;
    if (act !== exp) begin
      failCnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flagUnexpected(input string name);
    assertCnt++;
    failCnt++;
    $display("[TB] FAIL %s: event seen with nothing expected", name);
  endtask

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor A: acks and memory strobes popped against the scoreboard queues
  always @(negedge clk) begin
    resp_t  r;
    memop_t m;
    if (busA.ack0 && busA.ack1) flagUnexpected("A ack0 and ack1 together");
    else if (busA.ack0 || busA.ack1) begin
      if (respQA.size() == 0) flagUnexpected("A ack");
      else begin
        r = respQA.pop_front();
        checkOutput("A ack port", busA.ack1, r.port);
        checkOutput("A ack cycle", cycleCnt, r.ackCycle);
        checkOutput("A rdata", busA.rdata, r.rdata);
      end
    end
    if (busA.mem_read && busA.mem_write) flagUnexpected("A mem_read and mem_write together");
    else if (busA.mem_read || busA.mem_write) begin
      if (memQA.size() == 0) flagUnexpected("A mem strobe");
      else begin
        m = memQA.pop_front();
        checkOutput("A mem_write", busA.mem_write, m.isWrite);
        checkOutput("A mem_addr", busA.mem_addr, m.addr);
        if (m.isWrite) checkOutput("A mem_wdata", busA.mem_wdata, m.wdata);
      end
    end else checkOutput("A mem_wdata idle", busA.mem_wdata, '0);
  end

  always @(negedge clk) begin
    resp_t  r;
    memop_t m;
    if (busB.ack0 && busB.ack1) flagUnexpected("B ack0 and ack1 together");
    else if (busB.ack0 || busB.ack1) begin
      if (respQB.size() == 0) flagUnexpected("B ack");
      else begin
        r = respQB.pop_front();
        checkOutput("B ack port", busB.ack1, r.port);
        checkOutput("B ack cycle", cycleCnt, r.ackCycle);
        checkOutput("B rdata", busB.rdata, r.rdata);
      end
    end
    if (busB.mem_read || busB.mem_write) begin
      if (memQB.size() == 0) flagUnexpected("B mem strobe");
      else begin
        m = memQB.pop_front();
        checkOutput("B mem_read", busB.mem_read, !m.isWrite);
        checkOutput("B mem_addr", busB.mem_addr, m.addr);
      end
    end
  end

  task automatic applyStimulus(input logic port, input logic we, input logic [4:0] addr,
                               input logic [511:0] wdata);
    if (port) begin
      busA.req1 = 1'b1; busA.we1 = we; busA.addr1 = addr; busA.wdata1 = wdata;
    end else begin
      busA.req0 = 1'b1; busA.we0 = we; busA.addr0 = addr; busA.wdata0 = wdata;
    end
  endtask

  initial begin
    int g;
    cycleCnt = 0; assertCnt = 0; failCnt = 0; rdExpA = '0;
    rst_n = 1'b0;
    busA.req0 = 0; busA.req1 = 0; busA.we0 = 0; busA.we1 = 0;
    busA.addr0 = 0; busA.addr1 = 0; busA.wdata0 = '0; busA.wdata1 = '0;
    busB.req0 = 0; busB.req1 = 0; busB.we0 = 0; busB.we1 = 0;
    busB.addr0 = 0; busB.addr1 = 0; busB.wdata0 = '0; busB.wdata1 = '0;
    applyStimulus(1'b0, 1'b1, 5'd5, PAT_P0);
    applyStimulus(1'b1, 1'b1, 5'd6, PAT_P1);
    waitNeg(2);
    checkOutput("reset busy", busA.busy, 1'b0);
    checkOutput("reset ack0", busA.ack0, 1'b0);
    checkOutput("reset ack1", busA.ack1, 1'b0);
    checkOutput("reset mem_read", busA.mem_read, 1'b0);
    checkOutput("reset mem_write", busA.mem_write, 1'b0);
    checkOutput("reset rdata", busA.rdata, '0);
    checkOutput("reset mem_addr", busA.mem_addr, '0);
    checkOutput("reset B busy", busB.busy, 1'b0);

    $display("[TB] round robin with both ports requesting from reset");
    rst_n = 1'b1;
    g = cycleCnt + 1;
    for (int k = 0; k < 4; k++) begin
      respQA.push_back('{k[0], rdExpA, g + 1 + 3 * k});
      memQA.push_back('{1'b1, k[0] ? 5'd6 : 5'd5, k[0] ? PAT_P1 : PAT_P0});
    end
    waitNeg(11);
    busA.req0 = 0; busA.req1 = 0;
    waitNeg(2);

    $display("[TB] port 0 write then read of block 3");
    applyStimulus(1'b0, 1'b1, 5'd3, PAT_A);
    g = cycleCnt + 1;
    respQA.push_back('{1'b0, rdExpA, g + 1});
    memQA.push_back('{1'b1, 5'd3, PAT_A});
    waitNeg(1);
    busA.req0 = 0; busA.addr0 = 5'd9; busA.wdata0 = ~PAT_A;
    waitNeg(3);
    applyStimulus(1'b0, 1'b0, 5'd3, '0);
    g = cycleCnt + 1;
    rdExpA = PAT_A;
    respQA.push_back('{1'b0, rdExpA, g + 2});
    memQA.push_back('{1'b0, 5'd3, '0});
    waitNeg(1);
    busA.req0 = 0;
    waitNeg(4);

    $display("[TB] port 0 back-to-back writes");
    applyStimulus(1'b0, 1'b1, 5'd7, PAT_B);
    g = cycleCnt + 1;
    respQA.push_back('{1'b0, rdExpA, g + 1});
    respQA.push_back('{1'b0, rdExpA, g + 4});
    memQA.push_back('{1'b1, 5'd7, PAT_B});
    memQA.push_back('{1'b1, 5'd8, PAT_C});
    waitNeg(1);
    busA.addr0 = 5'd8; busA.wdata0 = PAT_C;
    waitNeg(3);
    busA.req0 = 0;
    waitNeg(3);

    $display("[TB] contending reads after a port 0 grant");
    applyStimulus(1'b0, 1'b0, 5'd3, '0);
    applyStimulus(1'b1, 1'b0, 5'd7, '0);
    g = cycleCnt + 1;
    respQA.push_back('{1'b1, PAT_B, g + 2});
    respQA.push_back('{1'b0, PAT_A, g + 6});
    memQA.push_back('{1'b0, 5'd7, '0});
    memQA.push_back('{1'b0, 5'd3, '0});
    rdExpA = PAT_A;
    waitNeg(6);
    busA.req0 = 0; busA.req1 = 0;
    waitNeg(3);

    $display("[TB] reset during WAIT aborts the read");
    applyStimulus(1'b1, 1'b0, 5'd8, '0);
    memQA.push_back('{1'b0, 5'd8, '0});
    waitNeg(1);
    busA.req1 = 0;
    waitNeg(1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", busA.busy, 1'b0);
    checkOutput("abort ack1", busA.ack1, 1'b0);
    checkOutput("abort rdata", busA.rdata, '0);
    checkOutput("abort mem_addr", busA.mem_addr, '0);
    rdExpA = '0;
    waitNeg(2);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 5'd8, '0);
    g = cycleCnt + 1;
    rdExpA = PAT_C;
    respQA.push_back('{1'b1, rdExpA, g + 2});
    memQA.push_back('{1'b0, 5'd8, '0});
    waitNeg(1);
    busA.req1 = 0;
    waitNeg(4);

    $display("[TB] port 1 read with READ_WAIT of 3");
    busB.req1 = 1; busB.we1 = 0; busB.addr1 = 5'd2;
    g = cycleCnt + 1;
    respQB.push_back('{1'b1, patB(5'd2), g + 4});
    memQB.push_back('{1'b0, 5'd2, '0});
    for (int k = 0; k < 5; k++) begin
      waitNeg(1);
      busB.req1 = 0;
      checkOutput("B busy in transaction", busB.busy, 1'b1);
    end
    waitNeg(1);
    checkOutput("B busy after RESP", busB.busy, 1'b0);

    waitNeg(2);
    checkOutput("A responses outstanding", respQA.size(), 0);
    checkOutput("A strobes outstanding", memQA.size(), 0);
    checkOutput("B responses outstanding", respQB.size(), 0);
    checkOutput("B strobes outstanding", memQB.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
